tcm_enc_trellis: RTL

Frame-based 4D-8PSK TCM encoder. It takes one information word per 4D symbol and runs the coded bits through a systematic feedback convolutional encoder with 2^(pCONSTR_LENGTH-1) states. It then maps the resulting 12-bit coded word onto four 3-bit 8PSK phase indices. The block is the transmit-side counterpart of the decoder's trellis, path-metric and traceback chain, which searches for the best state over all states; for that reason frames are unterminated and start in state 0.

---
 rtl/tcm_enc_trellis_pkg.sv | 48 ++++
 rtl/tcm_enc_trellis_mapper.sv | 22 ++
 rtl/tcm_enc_trellis.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/tcm_enc_trellis_pkg.sv
`default_nettype none
// ============================================================================
// Package     : tcm_enc_types
// Description : Shared types for the 4D-8PSK TCM encoder: state and coded-word
//               vectors, 8PSK phase indices, rate enum and info-width helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package tcm_enc_types;

  // Encoder state width for the default constraint length of 7
  localparam int cSTATE_W = 6;
  localparam int cCODEW_W = 12;
  localparam int cPHASE_W = 3;
  localparam int cINFO_W  = 11;

  typedef logic [cSTATE_W-1:0] stateb_t;
  typedef logic [cCODEW_W-1:0] codew_t;
  typedef logic [cPHASE_W-1:0] phase_t;

  // Four phase indices per 4D symbol, element 0 in the LSBs
  typedef phase_t [3:0] symb4_t;

  // Rate selector: number of info bits carried per 4D symbol
  typedef enum logic [1:0] {
    RATE_8  = 2'd0,
    RATE_9  = 2'd1,
    RATE_10 = 2'd2,
    RATE_11 = 2'd3
  } rate_t;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } fsm_state_t;

  // Number of info bits per word for a given rate (8..11)
  function automatic logic [3:0] info_width(input rate_t r);
    return 4'd8 + {2'b00, r};
  endfunction

  // Mask of the info bits that are significant at a given rate.
  // For 11 bits the shift wraps to zero and the subtraction yields all ones.
  function automatic logic [cINFO_W-1:0] info_mask(input rate_t r);
    return (11'd1 << info_width(r)) - 11'd1;
  endfunction

endpackage : tcm_enc_types
`default_nettype wire

// File: rtl/tcm_enc_trellis_mapper.sv
`default_nettype none
// ============================================================================
// Module      : tcm_enc_mapper
// Description : Combinational coded word -> four 3-bit 8PSK phase indices.
//               Kept as its own slice so alternative labelings (Gray,
//               set partitioning) stay local to this file.
// Revision    : 1.0 - initial release
// ============================================================================
module tcm_enc_mapper
  import tcm_enc_types::*;
(
  input  codew_t w,
  output symb4_t symb
);

  // Natural mapping: phase i takes coded bits [3i+2:3i]
  for (genvar i = 0; i < 4; i++) begin : g_map
    assign symb[i] = w[3*i +: 3];
  end

endmodule : tcm_enc_mapper
`default_nettype wire

// File: rtl/tcm_enc_trellis.sv
`default_nettype none
// ============================================================================
// Module      : tcm_enc_trellis
// Description : Frame-based 4D-8PSK TCM encoder. Systematic feedback
//               convolutional encoder (2^(K-1) states, unterminated frames
//               starting in state 0) followed by a 12-bit -> 4x8PSK mapper.
//               Two-stage pipeline: stage 1 holds the coded word and frame
//               flags, stage 2 holds the mapped symbol.
// Revision    : 1.0 - initial release
// ============================================================================
module tcm_enc_trellis
  import tcm_enc_types::*;
#(
  parameter int                      pCONSTR_LENGTH = 7,
  parameter logic [pCONSTR_LENGTH-1:0] pH0          = 7'o103,
  parameter logic [pCONSTR_LENGTH-1:0] pH1          = 7'o024,
  parameter logic [pCONSTR_LENGTH-1:0] pH2          = 7'o052,
  parameter logic [pCONSTR_LENGTH-1:0] pH3          = 7'o014
)(
  input  logic                        iclk,
  input  logic                        ireset,
  input  logic                        iclkena,
  input  logic [1:0]                  icode,
  input  logic                        ival,
  input  logic                        isop,
  input  logic                        ieop,
  input  logic [10:0]                 idat,
  output logic                        oval,
  output logic                        osop,
  output logic                        oeop,
  output symb4_t                      osymb,
  output logic [pCONSTR_LENGTH-2:0]   ostate,
  output logic [15:0]                 ocnt,
  output logic                        oerr
);

  localparam int cV = pCONSTR_LENGTH - 1;

  // Encoder next state: shift toward bit 0, feed back z0 = s[0] through h0
  // (bit v of h0 lands at position v-1), and inject x1..x3 through h1..h3.
  function automatic logic [cV-1:0] enc_next(input logic [cV-1:0] s,
                                             input logic x1,
                                             input logic x2,
                                             input logic x3);
    logic [cV-1:0] n;
    n = s >> 1;
    if (s[0]) n = n ^ pH0[cV:1];
    if (x1)   n = n ^ pH1[cV-1:0];
    if (x2)   n = n ^ pH2[cV-1:0];
    if (x3)   n = n ^ pH3[cV-1:0];
    return n;
  endfunction

  // Frame control
  fsm_state_t fsm_state;
  fsm_state_t fsm_next;
  logic       accept;
  logic       word_err;

  // Frame context carried across words
  logic [cV-1:0] enc_state;
  rate_t         rate_r;
  logic [15:0]   cnt_r;

  // Context as seen by the current word (isop overrides the stored one)
  logic [cV-1:0] cur_state;
  rate_t         cur_rate;
  logic [15:0]   cur_cnt;
  logic [10:0]   info;
  codew_t        word;
  logic [cV-1:0] nxt_state;
  logic [15:0]   nxt_cnt;

  // Stage 1
  logic          s1_val;
  logic          s1_sop;
  logic          s1_eop;
  codew_t        s1_w;
  logic [cV-1:0] s1_state;
  logic [15:0]   s1_cnt;

  // Mapper output
  symb4_t        map_symb;

  // FSM state register
  always_ff @(posedge iclk or posedge ireset) begin
    if (ireset)       fsm_state <= IDLE;
    else if (iclkena) fsm_state <= fsm_next;
  end

  // FSM next state: isop always (re)starts a frame, ieop closes it
  always_comb begin
    fsm_next = fsm_state;
    accept   = 1'b0;
    word_err = 1'b0;
    if (ival) begin
      if (isop || (fsm_state == ACTIVE)) begin
        accept   = 1'b1;
        fsm_next = ieop ? IDLE : ACTIVE;
      end else begin
        word_err = 1'b1;
      end
    end
  end

  // Per-word encoding: pick context, mask info bits, build coded word
  always_comb begin
    cur_state = isop ? '0 : enc_state;
    cur_rate  = isop ? rate_t'(icode) : rate_r;
    cur_cnt   = isop ? 16'd0 : cnt_r;
    info      = idat & info_mask(cur_rate);
    word      = {info[10:3], info[2], info[1], info[0], cur_state[0]};
    nxt_state = enc_next(cur_state, info[0], info[1], info[2]);
    nxt_cnt   = (cur_cnt == 16'hFFFF) ? cur_cnt : cur_cnt + 16'd1;
  end

  // Frame context update on every accepted word
  always_ff @(posedge iclk or posedge ireset) begin
    if (ireset) begin
      enc_state <= '0;
      rate_r    <= RATE_8;
      cnt_r     <= 16'd0;
    end else if (iclkena && accept) begin
      enc_state <= nxt_state;
      rate_r    <= cur_rate;
      cnt_r     <= nxt_cnt;
    end
  end

  // Stage 1 register: coded word, flags, state, index and error pulse
  always_ff @(posedge iclk or posedge ireset) begin
    if (ireset) begin
      s1_val   <= 1'b0;
      s1_sop   <= 1'b0;
      s1_eop   <= 1'b0;
      s1_w     <= '0;
      s1_state <= '0;
      s1_cnt   <= 16'd0;
      oerr     <= 1'b0;
    end else if (iclkena) begin
      s1_val   <= accept;
      s1_sop   <= accept & isop;
      s1_eop   <= accept & ieop;
      s1_w     <= word;
      s1_state <= cur_state;
      s1_cnt   <= cur_cnt;
      oerr     <= word_err;
    end
  end

  tcm_enc_mapper u_mapper (
    .w    (s1_w),
    .symb (map_symb)
  );

  // Stage 2 register: mapped symbol and its side information
  always_ff @(posedge iclk or posedge ireset) begin
    if (ireset) begin
      oval   <= 1'b0;
      osop   <= 1'b0;
      oeop   <= 1'b0;
      osymb  <= '0;
      ostate <= '0;
      ocnt   <= 16'd0;
    end else if (iclkena) begin
      oval   <= s1_val;
      osop   <= s1_sop;
      oeop   <= s1_eop;
      osymb  <= map_symb;
      ostate <= s1_state;
      ocnt   <= s1_cnt;
    end
  end

endmodule : tcm_enc_trellis
`default_nettype wire
